// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: state codes, flash opcodes and command lengths shared by
// the SPI flash image loader and its bit engine.
package flash_loader_pkg;

  // Loader state codes (kept as plain constants for legacy tool flows)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAKE_CMD  = 3'd1;
  localparam state_t ST_WAKE_WAIT = 3'd2;
  localparam state_t ST_READ_CMD  = 3'd3;
  localparam state_t ST_READ_DATA = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  // Flash opcodes
  localparam logic [7:0] FLASH_OP_READ = 8'h03;
  localparam logic [7:0] FLASH_OP_WAKE = 8'hAB;

  // Read command is opcode plus 24-bit address; wake is the bare opcode
  localparam int CMD_LEN  = 32;
  localparam int WAKE_LEN = 8;

endpackage

// File: rtl/spi_bit_engine.sv
// spi_bit_engine: mode-0 SPI shifter running at clk/2. Shifts out a
// left-aligned command word (zeros once it is exhausted) and shifts in the
// same number of bits. bit_valid marks the cycle a MISO bit is captured.
module spi_bit_engine
  import flash_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        nbits,
  input  logic [CMD_LEN-1:0] tx_data,
  input  logic               spi_miso,
  output logic               busy,
  output logic               bit_valid,
  output logic [15:0]        rx_data,
  output logic               spi_sclk,
  output logic               spi_mosi
);

  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic [CMD_LEN-1:0] tx_q, tx_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [15:0]        rx_q, rx_d;

  // Next-state: rise SCLK on low cycles, capture MISO and present next MOSI bit on high cycles
  always_comb begin
    busy_d    = busy_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    bit_valid = 1'b0;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = tx_data[CMD_LEN-1];
        tx_d   = {tx_data[CMD_LEN-2:0], 1'b0};
        cnt_d  = nbits;
      end
    end else if (!sclk_q) begin
      sclk_d = 1'b1;
    end else begin
      bit_valid = 1'b1;
      rx_d      = {rx_q[14:0], spi_miso};
      cnt_d     = cnt_q - 32'd1;
      sclk_d    = 1'b0;
      if (cnt_q == 32'd1) begin
        busy_d = 1'b0;
        mosi_d = 1'b0;
      end else begin
        mosi_d = tx_q[CMD_LEN-1];
        tx_d   = {tx_q[CMD_LEN-2:0], 1'b0};
      end
    end
  end

  // Engine registers; reset leaves SCLK and MOSI idle low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      tx_q   <= '0;
      cnt_q  <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      tx_q   <= tx_d;
      cnt_q  <= cnt_d;
      rx_q   <= rx_d;
    end
  end

  assign busy     = busy_q;
  assign rx_data  = rx_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: rtl/spi_flash_loader.sv
// spi_flash_loader: boot-time copy of a frame image from SPI flash into the
// VRAM write port, 16 bits per write, then raises a sticky 'loaded'.
// Optional flash wake-up (0xAB plus hold-off) is enabled by defining
// SPI_FLASH_LOADER_WAKE_EN.
module spi_flash_loader
  import flash_loader_pkg::*;
#(
  parameter logic [23:0] START_ADDR = 24'h100000,
  parameter int          WORDS      = 9600,
  parameter int          AW         = 14,
  parameter int          WAKE_WAIT  = 100
) (
  input  logic          clk,
  input  logic          rst,
  output logic          spi_cs,
  output logic          spi_sclk,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic [AW-1:0] waddr,
  output logic [15:0]   wdata,
  output logic          wen,
  output logic          loaded
);

`ifdef SPI_FLASH_LOADER_WAKE_EN
  localparam logic WAKE_EN = 1'b1;
`else
  localparam logic WAKE_EN = 1'b0;
`endif

  // The read covers the command and every data bit as one unbroken transfer
  localparam logic [31:0]        READ_BITS = 32'(CMD_LEN + 16 * WORDS);
  localparam logic [31:0]        WAKE_BITS = 32'(WAKE_LEN);
  localparam logic [CMD_LEN-1:0] READ_WORD = {FLASH_OP_READ, START_ADDR};
  localparam logic [CMD_LEN-1:0] WAKE_WORD = {FLASH_OP_WAKE, 24'h000000};
  localparam logic [AW-1:0]      LAST_ADDR = AW'(WORDS - 1);
  localparam logic [31:0]        WAIT_LAST = 32'(WAKE_WAIT - 1);

  state_t        state_q, state_d;
  logic          cs_q, cs_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic          loaded_q, loaded_d;
  logic [4:0]    cmd_cnt_q, cmd_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          word_full_q, word_full_d;
  logic          fin_q, fin_d;
  logic [31:0]   wait_cnt_q, wait_cnt_d;

  logic               eng_start;
  logic [31:0]        eng_nbits;
  logic [CMD_LEN-1:0] eng_tx;
  logic               eng_busy;
  logic               eng_bit_valid;
  logic [15:0]        eng_rx;

  spi_bit_engine u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .nbits     (eng_nbits),
    .tx_data   (eng_tx),
    .spi_miso  (spi_miso),
    .busy      (eng_busy),
    .bit_valid (eng_bit_valid),
    .rx_data   (eng_rx),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi)
  );

  // Sequencer: wake (optional), read command, data words, then park in DONE
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    loaded_d    = loaded_q;
    cmd_cnt_d   = cmd_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    word_full_d = 1'b0;
    fin_d       = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    eng_start   = 1'b0;
    eng_nbits   = READ_BITS;
    eng_tx      = READ_WORD;
    case (state_q)
      ST_IDLE: begin
        if (!eng_busy) begin
          eng_start = 1'b1;
          cs_d      = 1'b0;
          if (WAKE_EN) begin
            eng_nbits = WAKE_BITS;
            eng_tx    = WAKE_WORD;
            state_d   = ST_WAKE_CMD;
          end else begin
            state_d   = ST_READ_CMD;
          end
        end
      end
      ST_WAKE_CMD: begin
        if (eng_bit_valid) begin
          if (cmd_cnt_q == 5'(WAKE_LEN - 1)) begin
            cmd_cnt_d  = 5'd0;
            cs_d       = 1'b1;
            wait_cnt_d = 32'd0;
            state_d    = ST_WAKE_WAIT;
          end else begin
            cmd_cnt_d = cmd_cnt_q + 5'd1;
          end
        end
      end
      ST_WAKE_WAIT: begin
        if (wait_cnt_q == WAIT_LAST && !eng_busy) begin
          eng_start = 1'b1;
          cs_d      = 1'b0;
          state_d   = ST_READ_CMD;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_READ_CMD: begin
        if (eng_bit_valid) begin
          if (cmd_cnt_q == 5'(CMD_LEN - 1)) begin
            cmd_cnt_d = 5'd0;
            state_d   = ST_READ_DATA;
          end else begin
            cmd_cnt_d = cmd_cnt_q + 5'd1;
          end
        end
      end
      ST_READ_DATA: begin
        if (eng_bit_valid) begin
          bit_cnt_d   = bit_cnt_q + 4'd1;
          word_full_d = (bit_cnt_q == 4'd15);
        end
        if (word_full_q) begin
          wen_d   = 1'b1;
          wdata_d = eng_rx;
        end
        if (wen_q) begin
          if (waddr_q == LAST_ADDR) begin
            fin_d = 1'b1;
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
        if (fin_q) begin
          cs_d     = 1'b1;
          loaded_d = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Loader registers; reset returns every output to idle and restarts the load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cs_q        <= 1'b1;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      loaded_q    <= 1'b0;
      cmd_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      word_full_q <= 1'b0;
      fin_q       <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      loaded_q    <= loaded_d;
      cmd_cnt_q   <= cmd_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      word_full_q <= word_full_d;
      fin_q       <= fin_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign spi_cs = cs_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign wen    = wen_q;
  assign loaded = loaded_q;

endmodule

// File: tb/tb_spi_flash_loader.sv
// tb_spi_flash_loader: drives a 4-word and a 1-word loader from one flash
// model and compares every cycle against a timing model of the load.
module tb_spi_flash_loader;

  localparam int AW = 14;
  localparam int WW = 10;
`ifdef SPI_FLASH_LOADER_WAKE_EN
  localparam int R_OFF = 16 + WW;
`else
  localparam int R_OFF = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_miso = 1'b0;

  logic cs4, sclk4, mosi4, wen4, loaded4;
  logic [AW-1:0] waddr4;
  logic [15:0] wdata4;
  logic cs1, sclk1, mosi1, wen1, loaded1;
  logic [AW-1:0] waddr1;
  logic [15:0] wdata1;

  int total = 0;
  int bad = 0;

  logic [7:0] img [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [15:0] exp_words [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [31:0] read_cmd_ref = 32'h03100000;
  logic [7:0] wake_ref = 8'hAB;

  always #5 clk = ~clk;

  spi_flash_loader #(.START_ADDR(24'h100000), .WORDS(4), .AW(AW), .WAKE_WAIT(WW)) dut4 (
    .clk(clk), .rst(rst), .spi_cs(cs4), .spi_sclk(sclk4), .spi_mosi(mosi4),
    .spi_miso(spi_miso), .waddr(waddr4), .wdata(wdata4), .wen(wen4), .loaded(loaded4));

  spi_flash_loader #(.START_ADDR(24'h100000), .WORDS(1), .AW(AW), .WAKE_WAIT(WW)) dut1 (
    .clk(clk), .rst(rst), .spi_cs(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1),
    .spi_miso(spi_miso), .waddr(waddr1), .wdata(wdata1), .wen(wen1), .loaded(loaded1));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs c cycles after the IDLE cycle, for a loader of w words
  task automatic modelAt(input int c, input int w, output logic cs, output logic sclk,
                         output logic mosi, output logic wen, output logic loaded,
                         output int waddr, output logic [15:0] wdata);
    int r;
    int bits;
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0; wen = 1'b0; loaded = 1'b0; waddr = 0; wdata = 16'h0;
    if (c < R_OFF) begin
      if (c < 16) begin
        cs = 1'b0;
        sclk = (c % 2 == 1);
        mosi = wake_ref[7 - c / 2];
      end
    end else begin
      r = c - R_OFF;
      bits = 32 + 16 * w;
      if (r < 2 * bits) begin
        sclk = (r % 2 == 1);
        mosi = (r < 64) ? read_cmd_ref[31 - r / 2] : 1'b0;
      end
      cs = (r >= 2 * bits + 3);
      loaded = (r >= 2 * bits + 3);
      for (int k = 0; k < w; k++) begin
        if (r == 97 + 32 * k) wen = 1'b1;
        if (r >= 97 + 32 * k) wdata = {img[2 * k], img[2 * k + 1]};
        if (r >= 98 + 32 * k && k < w - 1) waddr = k + 1;
      end
    end
  endtask

  // Flash model: records each chip-select frame, serves image bits after a read command
  int fl_cnt = 0;
  logic [31:0] fl_cmd = 32'h0;
  logic cs_prev = 1'b1;
  logic sclk_prev = 1'b0;
  int frame_bits[$];
  logic [31:0] frame_cmd[$];
  always @(cs4, sclk4, rst) begin
    if (rst) begin
      frame_bits.delete();
      frame_cmd.delete();
      fl_cnt = 0;
      spi_miso = 1'b0;
    end else begin
      if (cs4 != cs_prev) begin
        if (!cs4) begin
          fl_cnt = 0;
          fl_cmd = 32'h0;
          spi_miso = 1'b0;
        end else begin
          frame_bits.push_back(fl_cnt);
          frame_cmd.push_back(fl_cmd);
        end
      end
      if (sclk4 != sclk_prev && !cs4) begin
        if (sclk4) begin
          if (fl_cnt < 32) fl_cmd = {fl_cmd[30:0], mosi4};
          fl_cnt++;
        end else if (fl_cnt >= 32 && fl_cmd[31:24] == 8'h03) begin
          if (fl_cnt - 32 < 64) spi_miso = img[(fl_cnt - 32) / 8][7 - (fl_cnt - 32) % 8];
          else spi_miso = 1'b0;
        end
      end
    end
    cs_prev = cs4;
    sclk_prev = sclk4;
  end

  // Per-cycle compare against the model plus event logs for the literal checks
  int c = 0;
  logic prev_cs4 = 1'b1;
  int wen4_c[$];
  int wen4_a[$];
  logic [15:0] wen4_d[$];
  int wen1_c[$];
  int wen1_a[$];
  logic [15:0] wen1_d[$];
  int fall_c[$];
  int load4_c = -1;
  int load1_c = -1;
  always @(negedge clk) begin
    logic e_cs, e_sclk, e_mosi, e_wen, e_loaded;
    int e_waddr;
    logic [15:0] e_wdata;
    if (rst) begin
      c = 0;
      prev_cs4 = 1'b1;
      wen4_c.delete(); wen4_a.delete(); wen4_d.delete();
      wen1_c.delete(); wen1_a.delete(); wen1_d.delete();
      fall_c.delete();
      load4_c = -1;
      load1_c = -1;
    end else begin
      modelAt(c, 4, e_cs, e_sclk, e_mosi, e_wen, e_loaded, e_waddr, e_wdata);
      checkOutput($sformatf("c%0d w4 cs", c), 32'(cs4), 32'(e_cs));
      checkOutput($sformatf("c%0d w4 sclk", c), 32'(sclk4), 32'(e_sclk));
      checkOutput($sformatf("c%0d w4 mosi", c), 32'(mosi4), 32'(e_mosi));
      checkOutput($sformatf("c%0d w4 wen", c), 32'(wen4), 32'(e_wen));
      checkOutput($sformatf("c%0d w4 loaded", c), 32'(loaded4), 32'(e_loaded));
      checkOutput($sformatf("c%0d w4 waddr", c), 32'(waddr4), 32'(e_waddr));
      checkOutput($sformatf("c%0d w4 wdata", c), 32'(wdata4), 32'(e_wdata));
      modelAt(c, 1, e_cs, e_sclk, e_mosi, e_wen, e_loaded, e_waddr, e_wdata);
      checkOutput($sformatf("c%0d w1 cs", c), 32'(cs1), 32'(e_cs));
      checkOutput($sformatf("c%0d w1 sclk", c), 32'(sclk1), 32'(e_sclk));
      checkOutput($sformatf("c%0d w1 mosi", c), 32'(mosi1), 32'(e_mosi));
      checkOutput($sformatf("c%0d w1 wen", c), 32'(wen1), 32'(e_wen));
      checkOutput($sformatf("c%0d w1 loaded", c), 32'(loaded1), 32'(e_loaded));
      checkOutput($sformatf("c%0d w1 waddr", c), 32'(waddr1), 32'(e_waddr));
      checkOutput($sformatf("c%0d w1 wdata", c), 32'(wdata1), 32'(e_wdata));
      if (wen4) begin wen4_c.push_back(c); wen4_a.push_back(int'(waddr4)); wen4_d.push_back(wdata4); end
      if (wen1) begin wen1_c.push_back(c); wen1_a.push_back(int'(waddr1)); wen1_d.push_back(wdata1); end
      if (prev_cs4 && !cs4) fall_c.push_back(c);
      if (loaded4 && load4_c < 0) load4_c = c;
      if (loaded1 && load1_c < 0) load1_c = c;
      prev_cs4 = cs4;
      c++;
    end
  end

  task automatic applyStimulus(input logic rst_val);
    @(negedge clk);
    #1 rst = rst_val;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " cs"}, 32'(cs4), 32'd1);
    checkOutput({tag, " sclk"}, 32'(sclk4), 32'd0);
    checkOutput({tag, " mosi"}, 32'(mosi4), 32'd0);
    checkOutput({tag, " waddr"}, 32'(waddr4), 32'd0);
    checkOutput({tag, " wdata"}, 32'(wdata4), 32'd0);
    checkOutput({tag, " wen"}, 32'(wen4), 32'd0);
    checkOutput({tag, " loaded"}, 32'(loaded4), 32'd0);
  endtask

  task automatic waitLoaded(input string tag);
    int n = 0;
    while (!loaded4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!loaded4) checkOutput({tag, " load timeout"}, 32'(loaded4), 32'd1);
  endtask

  // Hand-computed expectations for one complete load
  task automatic checkRun(input string tag);
    int quiet = 0;
    repeat (40) @(negedge clk) if (sclk4 || !cs4 || wen4 || !loaded4) quiet++;
    checkOutput({tag, " quiet after done"}, 32'(quiet), 32'd0);
    checkOutput({tag, " wen4 count"}, 32'(wen4_c.size()), 32'd4);
    for (int k = 0; k < 4 && k < wen4_c.size(); k++) begin
      checkOutput($sformatf("%s wen4[%0d] addr", tag, k), 32'(wen4_a[k]), 32'(k));
      checkOutput($sformatf("%s wen4[%0d] data", tag, k), 32'(wen4_d[k]), 32'(exp_words[k]));
      checkOutput($sformatf("%s wen4[%0d] cycle", tag, k), 32'(wen4_c[k]), 32'(R_OFF + 97 + 32 * k));
    end
    checkOutput({tag, " loaded4 cycle"}, 32'(load4_c), 32'(R_OFF + 97 + 96 + 2));
    checkOutput({tag, " wen1 count"}, 32'(wen1_c.size()), 32'd1);
    if (wen1_c.size() > 0) begin
      checkOutput({tag, " wen1 addr"}, 32'(wen1_a[0]), 32'd0);
      checkOutput({tag, " wen1 data"}, 32'(wen1_d[0]), 32'h1234);
    end
    checkOutput({tag, " loaded1 cycle"}, 32'(load1_c), 32'(R_OFF + 99));
    checkOutput({tag, " first cs fall"}, 32'(fall_c.size() > 0 ? fall_c[0] : -1), 32'd0);
`ifdef SPI_FLASH_LOADER_WAKE_EN
    checkOutput({tag, " frames"}, 32'(frame_bits.size()), 32'd2);
    checkOutput({tag, " read cs fall"}, 32'(fall_c.size() > 1 ? fall_c[1] : -1), 32'd26);
    if (frame_bits.size() == 2) begin
      checkOutput({tag, " wake bits"}, 32'(frame_bits[0]), 32'd8);
      checkOutput({tag, " wake opcode"}, 32'(frame_cmd[0][7:0]), 32'hAB);
      checkOutput({tag, " read bits"}, 32'(frame_bits[1]), 32'd96);
      checkOutput({tag, " read cmd"}, frame_cmd[1], 32'h03100000);
    end
`else
    checkOutput({tag, " frames"}, 32'(frame_bits.size()), 32'd1);
    if (frame_bits.size() == 1) begin
      checkOutput({tag, " read bits"}, 32'(frame_bits[0]), 32'd96);
      checkOutput({tag, " read cmd"}, frame_cmd[0], 32'h03100000);
      checkOutput({tag, " first opcode"}, 32'(frame_cmd[0][31:24]), 32'h03);
    end
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 checkReset("por");
    applyStimulus(1'b0);
    waitLoaded("run1");
    checkRun("run1");

    applyStimulus(1'b1);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0);
    repeat (R_OFF + 139) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkReset("midrst");
    checkOutput("midrst writes before reset", 32'(wen4_c.size()), 32'd2);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0);
    waitLoaded("rerun");
    checkRun("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
